// File: rtl/sw_mode_pkg.sv
// -----------------------------------------------------------------------------
// sw_mode_pkg
// Shared definitions for the switch-mode timer:
//   MODE_STOP     - mode code that halts the prescaler
//   apply_e       - what the mode-apply logic does on a given cycle
//   mode_period() - tick period (in clk cycles) for a mode index
//   params_legal()- elaboration-time legality check of the timer parameters
// -----------------------------------------------------------------------------
package sw_mode_pkg;

  localparam int MODE_STOP = 0;

  // Mode-apply decision, evaluated in priority order every cycle.
  typedef enum logic [1:0] {
    APPLY_HOLD  = 2'd0,  // pending equals active: keep counting
    APPLY_STOP  = 2'd1,  // pending is stop: halt on the next edge
    APPLY_START = 2'd2,  // stopped and pending is a run mode: load now
    APPLY_DEFER = 2'd3   // both running, different: switch at terminal count
  } apply_e;

  // period(0) = 0; period(k) = base << (num_modes-1-k), so higher modes tick
  // faster and mode num_modes-1 runs at the base period.
  function automatic longint unsigned mode_period(input int k, input int base,
                                                  input int num_modes);
    longint unsigned p;
    if (k == MODE_STOP) p = 64'd0;
    else                p = longint'(base) << (num_modes - 1 - k);
    return p;
  endfunction

  // The slowest running mode (k = 1) must fit in a cnt_w-bit counter.
  function automatic bit params_legal(input int mode_w, input int cnt_w,
                                      input int base, input int deb);
    longint unsigned p1;
    longint unsigned lim;
    bit              ok;
    ok = 1'b1;
    if (mode_w < 1 || mode_w > 5)  ok = 1'b0;
    if (cnt_w < 1 || cnt_w > 62)   ok = 1'b0;
    if (base < 2 || deb < 1)       ok = 1'b0;
    if (ok) begin
      p1  = mode_period(1, base, 1 << mode_w);
      lim = (64'd1 << cnt_w) - 64'd1;
      if (p1 > lim) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser followed by a stable-sample counter. The output only
// takes a new value once the synchronised input has been seen unchanged for
// DEB_CYCLES consecutive samples, so shorter glitches never reach dout.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   din  - raw W-bit input, asynchronous to clk
//   dout - debounced, clk-synchronous W-bit value (resets to 0)
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int SW = $clog2(DEB_CYCLES + 1);

  logic [W-1:0]  s1_q, s2_q, s3_q;   // s3_q is the previous s2 sample
  logic [SW-1:0] stab_q, stab_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          same;
  int            held;

  assign same = (s2_q == s3_q);

  always_comb begin
    stab_d = stab_q;
    dout_d = dout_q;
    // held = number of consecutive equal s2 samples including this one;
    // stab_q counts the repeats after the first, hence the +2.
    held   = same ? int'(stab_q) + 2 : 1;
    if (!same)                        stab_d = '0;
    else if (stab_q != SW'(DEB_CYCLES)) stab_d = stab_q + SW'(1);
    if (held >= DEB_CYCLES) dout_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      stab_q <= '0;
      dout_q <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      stab_q <= stab_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sw_mode_timer.sv
// -----------------------------------------------------------------------------
// sw_mode_timer
// Debounces a multi-bit mode switch, picks a power-of-two tick period for the
// selected mode and runs a prescaler that emits a one-cycle count_en strobe.
// Mode 0 stops the timer immediately; changes between running modes wait for
// the current period to finish so no short tick is ever produced.
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-low reset
//   sw_state    - raw mode switch (asynchronous)
//   tm_value    - period of the active mode in cycles, 0 when stopped
//   count_en    - registered one-cycle tick strobe
//   active_mode - mode currently driving the prescaler
//   running     - high when active_mode != 0
// -----------------------------------------------------------------------------
module sw_mode_timer
  import sw_mode_pkg::*;
#(
  parameter int MODE_W      = 2,
  parameter int CNT_W       = 27,
  parameter int BASE_PERIOD = 10,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] sw_state,
  output logic [CNT_W-1:0]  tm_value,
  output logic              count_en,
  output logic [MODE_W-1:0] active_mode,
  output logic              running
);

  localparam int                NUM_MODES = 1 << MODE_W;
  localparam logic [MODE_W-1:0] STOP      = MODE_W'(MODE_STOP);

  if (!params_legal(MODE_W, CNT_W, BASE_PERIOD, DEB_CYCLES)) begin : g_bad_params
    $error("sw_mode_timer: illegal parameters (period(1) must fit in CNT_W, BASE_PERIOD >= 2, DEB_CYCLES >= 1)");
  end

  logic [MODE_W-1:0] pend;
  logic [MODE_W-1:0] act_q, act_d;
  logic [CNT_W-1:0]  tm_q, tm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  pend_per;
  logic              cen_q, cen_d;
  logic              run_q, run_d;
  logic              term;
  apply_e            sel;

  sw_debounce #(
    .W          (MODE_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (sw_state),
    .dout (pend)
  );

  assign pend_per = CNT_W'(mode_period(int'(pend), BASE_PERIOD, NUM_MODES));

  // Terminal count of the running period; never true while stopped.
  assign term = (act_q != STOP) && (cnt_q == tm_q - CNT_W'(1));

  always_comb begin
    if (pend == act_q)      sel = APPLY_HOLD;
    else if (pend == STOP)  sel = APPLY_STOP;
    else if (act_q == STOP) sel = APPLY_START;
    else                    sel = APPLY_DEFER;
  end

  always_comb begin
    act_d = act_q;
    tm_d  = tm_q;
    cnt_d = cnt_q;
    cen_d = 1'b0;
    unique case (sel)
      APPLY_HOLD: begin
        if (act_q != STOP) begin
          if (term) begin
            cen_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      APPLY_STOP: begin
        // Abandon the partial period: no pulse.
        act_d = STOP;
        tm_d  = '0;
        cnt_d = '0;
      end
      APPLY_START: begin
        act_d = pend;
        tm_d  = pend_per;
        cnt_d = '0;
      end
      APPLY_DEFER: begin
        // The finishing period still gets its pulse; the new period starts
        // from the same edge. Whatever pend holds at that moment wins.
        if (term) begin
          cen_d = 1'b1;
          act_d = pend;
          tm_d  = pend_per;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    run_d = (act_d != STOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q <= STOP;
      tm_q  <= '0;
      cnt_q <= '0;
      cen_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      act_q <= act_d;
      tm_q  <= tm_d;
      cnt_q <= cnt_d;
      cen_q <= cen_d;
      run_q <= run_d;
    end
  end

  assign tm_value    = tm_q;
  assign count_en    = cen_q;
  assign active_mode = act_q;
  assign running     = run_q;

endmodule

// File: tb/tb_sw_mode_timer.sv
module tb_sw_mode_timer;

  localparam int MODE_W    = 2;
  localparam int CNT_W     = 8;
  localparam int BASE      = 10;
  localparam int DEB       = 4;
  localparam int NUM_MODES = 1 << MODE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [MODE_W-1:0] sw_state = '0;
  logic [CNT_W-1:0]  tm_value;
  logic              count_en;
  logic [MODE_W-1:0] active_mode;
  logic              running;

  int total = 0;
  int bad   = 0;

  sw_mode_timer #(
    .MODE_W(MODE_W), .CNT_W(CNT_W), .BASE_PERIOD(BASE), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .sw_state(sw_state), .tm_value(tm_value),
    .count_en(count_en), .active_mode(active_mode), .running(running)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pending mode: the last sampled switch value that was seen unchanged for
  // DEB consecutive samples, looking two samples back for the synchroniser.
  // Ticks: absolute cycle of the next pulse, set period cycles after a load.
  int cyc = 0;
  int m_act, m_pend, m_cen, m_nxt;
  int hist[$];

  function automatic int per(input int k);
    return (k == 0) ? 0 : (BASE << (NUM_MODES - 1 - k));
  endfunction

  function automatic void model_reset();
    m_act = 0; m_pend = 0; m_cen = 0; m_nxt = 0;
    hist.delete();
    repeat (DEB + 4) hist.push_back(0);
  endfunction

  function automatic void model_edge(input int sw);
    int p, a, n;
    bit stable;
    p = m_pend; a = m_act; m_cen = 0;
    if (p == a) begin
      if (a != 0 && cyc == m_nxt) begin m_cen = 1; m_nxt = cyc + per(a); end
    end else if (p == 0) begin
      m_act = 0;
    end else if (a == 0) begin
      m_act = p; m_nxt = cyc + per(p);
    end else if (cyc == m_nxt) begin
      m_cen = 1; m_act = p; m_nxt = cyc + per(p);
    end
    hist.push_back(sw);
    void'(hist.pop_front());
    n = hist.size();
    stable = 1'b1;
    for (int j = 1; j < DEB; j++)
      if (hist[n-3-j] != hist[n-3]) stable = 1'b0;
    if (stable) m_pend = hist[n-3];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("count_en",    32'(count_en),    32'(m_cen));
    chk("active_mode", 32'(active_mode), 32'(m_act));
    chk("tm_value",    32'(tm_value),    32'(per(m_act)));
    chk("running",     32'(running),     32'(m_act != 0));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_edge(int'(sw_state));
    #1;
    check_outputs();
  endtask

  // Async reset asserted mid-cycle, held across hold_edges edges.
  task automatic async_reset(input int hold_edges);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (hold_edges) tick();
    rst = 1'b1;
  endtask

  task automatic wait_pulse(input int bound, output int n);
    bit seen;
    n = 0; seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      n++;
      if (count_en === 1'b1) seen = 1'b1;
    end
    chk("pulse_within_bound", 32'(seen), 32'd1);
  endtask

  initial begin
    int n, pc, hold;

    // 1. reset held with switch at 3
    rst = 1'b0; sw_state = 2'd3;
    model_reset();
    #1; check_outputs();
    repeat (5) tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("t1_tm_before_load", 32'(tm_value), 32'd0);
    tick();
    chk("t1_tm_load_edge7", 32'(tm_value), 32'd10);
    chk("t1_running", 32'(running), 32'd1);

    // 2. stop, then start mode 1 and measure pulse spacing
    sw_state = 2'd0;
    repeat (8) tick();
    chk("t2_stopped", 32'(tm_value), 32'd0);
    sw_state = 2'd1;
    repeat (7) tick();
    chk("t2_tm_mode1", 32'(tm_value), 32'd40);
    wait_pulse(60, n); chk("t2_first_pulse", 32'(n), 32'd40);
    wait_pulse(60, n); chk("t2_spacing", 32'(n), 32'd40);

    // 3. deferred switch 1 -> 3 requested at cnt = 5
    repeat (5) tick();
    sw_state = 2'd3;
    wait_pulse(60, n); chk("t3_mode1_pulse", 32'(n), 32'd35);
    chk("t3_tm_switched", 32'(tm_value), 32'd10);
    wait_pulse(20, n); chk("t3_next_pulse", 32'(n), 32'd10);

    // 4. go to mode 2, then stop at cnt = 12
    sw_state = 2'd2;
    repeat (17) tick();
    chk("t4_tm_mode2", 32'(tm_value), 32'd20);
    wait_pulse(30, n);
    repeat (12) tick();
    sw_state = 2'd0;
    repeat (6) tick();
    chk("t4_still_mode2", 32'(active_mode), 32'd2);
    tick();
    chk("t4_stop_mode", 32'(active_mode), 32'd0);
    chk("t4_stop_tm", 32'(tm_value), 32'd0);
    pc = 0;
    repeat (50) begin tick(); if (count_en === 1'b1) pc++; end
    chk("t4_no_pulses", 32'(pc), 32'd0);

    // 5. glitch rejection in mode 1, then an accepted 4-cycle excursion
    sw_state = 2'd1;
    repeat (7) tick();
    chk("t5_tm_mode1", 32'(tm_value), 32'd40);
    wait_pulse(60, n); chk("t5_first_pulse", 32'(n), 32'd40);
    repeat (10) tick();
    sw_state = 2'd2;
    repeat (3) tick();
    sw_state = 2'd1;
    wait_pulse(60, n); chk("t5_glitch_undisturbed", 32'(n), 32'd27);
    chk("t5_mode_kept", 32'(active_mode), 32'd1);
    repeat (30) tick();
    sw_state = 2'd2;
    repeat (4) tick();
    sw_state = 2'd1;
    wait_pulse(20, n); chk("t5_accept_pulse_at", 32'(n), 32'd6);
    chk("t5_accept_tm", 32'(tm_value), 32'd20);
    wait_pulse(30, n); chk("t5_back_to_1", 32'(n), 32'd20);
    chk("t5_back_tm", 32'(tm_value), 32'd40);

    // 6. reset mid-period in mode 3
    sw_state = 2'd3;
    wait_pulse(60, n);
    chk("t6_tm_mode3", 32'(tm_value), 32'd10);
    repeat (6) tick();
    async_reset(1);
    chk("t6_async_clear", 32'(tm_value), 32'd0);
    wait_pulse(40, n); chk("t6_first_pulse", 32'(n), 32'd17);

    // 7. random switch activity with occasional resets
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        sw_state = MODE_W'($urandom_range(0, NUM_MODES - 1));
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 80);
      end
      hold--;
      if ($urandom_range(0, 599) == 0) async_reset($urandom_range(1, 3));
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
